apb_debug_master: RTL and testbench



---
 rtl/apb_debug_master_if.sv | 32 +++
 rtl/apb_debug_master.sv | 120 ++++++++++++
 tb/tb_apb_debug_master.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_debug_master_if.sv
// Host command/response channel plus the APB segment of apb_debug_master.
// The master modport is the requester's view; slave is the host/APB-slave side.
interface apb_debug_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_debug_master.sv
// Single-outstanding APB requester: host command -> SETUP/ACCESS -> one response,
// with PREADY wait states and an optional stall timeout.
module apb_debug_master #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic                 PCLK,
  input logic                 PRESETn,
  apb_debug_master_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam int               CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_cmd_ready;
  logic             r_psel;
  logic             r_penable;
  logic             r_pwrite;
  logic [4:0]       r_paddr;
  logic [7:0]       r_pwdata;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_rdata;
  logic             r_rsp_timeout;
  logic             w_timeout_hit;

  // Expiry is judged on the count of stalled ACCESS cycles already seen, so
  // ACCESS lasts exactly TIMEOUT_CYCLES cycles when PREADY never rises.
  assign w_timeout_hit = TO_EN && (r_wait_cnt == CNT_LAST);

  // NOTE: every register, including the data-path ones, has an async reset
  // so a reset mid-transfer leaves the bus idle and no stale data visible.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_cmd_ready   <= 1'b1;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; every branch reads the
      // pre-edge values, which keeps this single-block FSM order-independent.
      unique case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_pwrite    <= bus.cmd_write;
            r_paddr     <= bus.cmd_addr;
            r_pwdata    <= bus.cmd_wdata;
            r_cmd_ready <= 1'b0;
            r_psel      <= 1'b1;
            r_state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          r_penable  <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= S_ACCESS;
        end

        S_ACCESS: begin
          if (bus.PREADY) begin
            r_rsp_rdata   <= r_pwrite ? 8'h00 : bus.PRDATA;
            r_rsp_timeout <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
          end else if (w_timeout_hit) begin
            r_rsp_rdata   <= 8'h00;
            r_rsp_timeout <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
          end else if (r_wait_cnt != '1) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.PSEL        = r_psel;
  assign bus.PENABLE     = r_penable;
  assign bus.PWRITE      = r_pwrite;
  assign bus.PADDR       = r_paddr;
  assign bus.PWDATA      = r_pwdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_debug_master.sv
// Directed self-checking bench for apb_debug_master (TIMEOUT_CYCLES = 15).
// The bench plays both host and APB slave through the interface.
module tb_apb_debug_master;

  logic PCLK = 1'b0;
  logic PRESETn;
  int   n_checks = 0;
  int   n_errors = 0;

  apb_debug_master_if bus ();

  apb_debug_master #(.TIMEOUT_CYCLES(15)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Present one command for a single edge; returns in the SETUP cycle.
  task automatic send_cmd(input logic w, input logic [4:0] a, input logic [7:0] d);
    check("accept_ready", bus.cmd_ready, 1'b1);
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("setup_cmd_ready", bus.cmd_ready, 1'b0);
    check("setup_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b10);
  endtask

  // Plays the APB slave: PREADY rises in ACCESS cycle waits+1 unless stall.
  // Returns in the first cycle after ACCESS with the ACCESS length counted.
  task automatic slave_access(input int waits, input logic [7:0] rd, input bit stall,
                              output int acc, output bit stable);
    logic [4:0] a0;
    logic [7:0] d0;
    logic       w0;
    a0 = bus.PADDR;
    d0 = bus.PWDATA;
    w0 = bus.PWRITE;
    acc    = 0;
    stable = 1'b1;
    bus.PREADY = 1'b0;
    bus.PRDATA = rd;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bus.PENABLE) break;
      acc++;
      if (!bus.PSEL || bus.PADDR != a0 || bus.PWDATA != d0 || bus.PWRITE != w0)
        stable = 1'b0;
      bus.PREADY = !stall && (acc == waits + 1);
    end
    bus.PREADY = 1'b0;
    check("access_bounded", acc < 40, 1'b1);
  endtask

  // Holds rsp_ready low for 'hold' cycles, then completes the handshake.
  task automatic release_rsp(input int hold);
    logic [7:0] held;
    bit         ok;
    held = bus.rsp_rdata;
    ok   = 1'b1;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held || bus.cmd_ready !== 1'b0 ||
          bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0)
        ok = 1'b0;
    end
    if (hold > 0) check("rsp_backpressure_hold", ok, 1'b1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("rsp_done_valid", bus.rsp_valid, 1'b0);
    check("rsp_done_cmd_ready", bus.cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit st;
    int setups[$];
    int k;
    bit pa_ok;
    bit quiet;
    logic [4:0] prev_pa;

    PRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;

    #2;
    check("rst_bus_idle", {bus.PSEL, bus.PENABLE, bus.rsp_valid}, 3'b000);
    repeat (2) @(posedge PCLK);
    #3 PRESETn = 1'b1;
    tick();
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_regs", {bus.PWRITE, bus.PADDR, bus.PWDATA, bus.rsp_rdata, bus.rsp_timeout}, '0);

    // Zero-wait write; PRDATA garbage must not reach rsp_rdata.
    send_cmd(1'b1, 5'h00, 8'h01);
    check("wr_setup_pwdata", bus.PWDATA, 8'h01);
    slave_access(0, 8'hFF, 1'b0, acc, st);
    check("wr_access_len", acc, 1);
    check("wr_apb_stable", st, 1'b1);
    check("wr_rsp_valid", bus.rsp_valid, 1'b1);
    check("wr_rsp_rdata", bus.rsp_rdata, 8'h00);
    check("wr_rsp_timeout", bus.rsp_timeout, 1'b0);
    check("wr_resp_bus_idle", {bus.PSEL, bus.PENABLE}, 2'b00);
    release_rsp(0);

    // Read with three wait states.
    send_cmd(1'b0, 5'h00, 8'h77);
    slave_access(3, 8'h0A, 1'b0, acc, st);
    check("rd3_access_len", acc, 4);
    check("rd3_apb_stable", st, 1'b1);
    check("rd3_rsp_valid", bus.rsp_valid, 1'b1);
    check("rd3_rsp_rdata", bus.rsp_rdata, 8'h0A);
    check("rd3_rsp_timeout", bus.rsp_timeout, 1'b0);
    release_rsp(0);

    // Stalled slave: abort after exactly 15 ACCESS cycles.
    send_cmd(1'b0, 5'h07, 8'h00);
    slave_access(0, 8'h99, 1'b1, acc, st);
    check("to_access_len", acc, 15);
    check("to_psel_low", bus.PSEL, 1'b0);
    check("to_rsp_valid", bus.rsp_valid, 1'b1);
    check("to_rsp_timeout", bus.rsp_timeout, 1'b1);
    check("to_rsp_rdata", bus.rsp_rdata, 8'h00);
    release_rsp(0);

    // Normal read after a timeout clears the timeout flag.
    send_cmd(1'b0, 5'h02, 8'h00);
    check("after_to_paddr", bus.PADDR, 5'h02);
    slave_access(0, 8'h5A, 1'b0, acc, st);
    check("after_to_rdata", bus.rsp_rdata, 8'h5A);
    check("after_to_timeout", bus.rsp_timeout, 1'b0);
    release_rsp(0);

    // Response backpressure for five cycles.
    send_cmd(1'b0, 5'h1F, 8'h00);
    slave_access(1, 8'hA5, 1'b0, acc, st);
    check("bp_access_len", acc, 2);
    check("bp_rsp_rdata", bus.rsp_rdata, 8'hA5);
    release_rsp(5);

    // PREADY arriving in the very cycle the timeout would expire wins.
    send_cmd(1'b0, 5'h15, 8'h00);
    slave_access(14, 8'h3C, 1'b0, acc, st);
    check("edge_access_len", acc, 15);
    check("edge_rsp_timeout", bus.rsp_timeout, 1'b0);
    check("edge_rsp_rdata", bus.rsp_rdata, 8'h3C);
    release_rsp(0);

    // Reset asserted mid-ACCESS drops the transfer immediately.
    send_cmd(1'b0, 5'h09, 8'h00);
    bus.PREADY = 1'b0;
    tick();
    check("rstmid_in_access", {bus.PSEL, bus.PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    check("rstmid_async_clear", {bus.PSEL, bus.PENABLE, bus.rsp_valid}, 3'b000);
    repeat (2) @(posedge PCLK);
    #3 PRESETn = 1'b1;
    tick();
    check("rstmid_cmd_ready", bus.cmd_ready, 1'b1);
    check("rstmid_paddr", bus.PADDR, 5'h00);
    bus.rsp_ready = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) quiet = 1'b0;
    end
    bus.rsp_ready = 1'b0;
    check("rstmid_no_response", quiet, 1'b1);

    // Back-to-back commands, cmd_valid held, rsp_ready tied high.
    pa_ok = 1'b1;
    k     = 0;
    bus.PREADY    = 1'b1;
    bus.PRDATA    = 8'h11;
    bus.rsp_ready = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 5'h10;
    bus.cmd_valid = 1'b1;
    prev_pa = bus.PADDR;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (bus.PSEL && !bus.PENABLE) begin
        setups.push_back(i);
        check("b2b_paddr", bus.PADDR, 5'h10 + k);
        k++;
        bus.cmd_addr = 5'h10 + 5'(k);
      end else if (bus.PADDR != prev_pa) begin
        pa_ok = 1'b0;
      end
      prev_pa = bus.PADDR;
    end
    bus.cmd_valid = 1'b0;
    bus.PREADY    = 1'b0;
    bus.rsp_ready = 1'b0;
    check("b2b_accept_count", setups.size(), 4);
    for (int j = 1; j < setups.size(); j++)
      check("b2b_period", setups[j] - setups[j-1], 4);
    check("b2b_paddr_only_at_accept", pa_ok, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
